alu_multicycle: RTL and testbench

//  Parametrised successor to the single-cycle EX-stage ALU: adds shifts, an iterative

---
 rtl/alu_multicycle.sv | 163 ++++++++++++++++
 tb/tb_alu_multicycle.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// EX-stage ALU: single-cycle logic/shift/compare ops, iterative MUL and restoring DIVU; 1 cycle or size+1 cycles.
// Result is held in DONE until ALU_Out_Ready; new operands are taken only in IDLE.
module alu_multicycle #(
    parameter int size = 32
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            ALU_In_Valid,
    output logic            ALU_In_Ready,
    input  logic [3:0]      AluOp_EX,
    input  logic [size-1:0] ALU_A,
    input  logic [size-1:0] ALU_B,
    output logic            ALU_Out_Valid,
    input  logic            ALU_Out_Ready,
    output logic [size-1:0] aluResult,
    output logic            Zero,
    output logic            DivByZero
);
    localparam int SHW = $clog2(size);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [3:0] OP_MUL  = 4'b1011;
    localparam logic [3:0] OP_DIVU = 4'b1100;
    localparam logic [SHW:0] CNT_INIT = (SHW+1)'(size);
    localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

    logic [1:0]      state_q, state_d;
    logic [SHW:0]    cnt_q, cnt_d;
    logic            is_mul_q, is_mul_d;
    logic [size-1:0] acc_q, acc_d;
    logic [size-1:0] opa_q, opa_d;
    logic [size-1:0] opb_q, opb_d;
    logic [size-1:0] result_q, result_d;
    logic            dbz_q, dbz_d;

    logic [size-1:0]        single_res;
    logic [size-1:0]        mul_acc, div_quot, div_rem;
    logic [size:0]          rem_shift, rem_diff;
    logic signed [size-1:0] sra_res;
    logic [SHW-1:0]         shamt;

    // Shifts move B by the amount held in A (MIPS operand order).
    assign shamt   = ALU_A[SHW-1:0];
    assign sra_res = $signed(ALU_B) >>> shamt;

    always_comb begin
        single_res = '0;
        case (AluOp_EX)
            4'b0000: single_res = ALU_A + ALU_B;
            4'b0001: single_res = ALU_A - ALU_B;
            4'b0010: single_res = ALU_A & ALU_B;
            4'b0011: single_res = ALU_A | ALU_B;
            4'b0100: single_res = ~(ALU_A | ALU_B);
            4'b0101: single_res = ALU_A ^ ALU_B;
            4'b0110: single_res = {{(size-1){1'b0}}, $signed(ALU_A) < $signed(ALU_B)};
            4'b0111: single_res = {{(size-1){1'b0}}, $signed(ALU_A) > $signed(ALU_B)};
            4'b1000: single_res = ALU_B << shamt;
            4'b1001: single_res = ALU_B >> shamt;
            4'b1010: single_res = sra_res;
            4'b1101: single_res = ~(ALU_A & ALU_B);
            4'b1110: single_res = ~(ALU_A ^ ALU_B);
            4'b1111: single_res = '1;
            default: single_res = '0;
        endcase
    end

    // MUL: acc += A<<i when B bit i set. DIVU: acc is the remainder, opa shifts
    // dividend bits out and quotient bits in. A zero divisor always "fits",
    // which yields the all-ones quotient.
    always_comb begin
        mul_acc   = acc_q + (opb_q[0] ? opa_q : '0);
        rem_shift = {acc_q, opa_q[size-1]};
        rem_diff  = rem_shift - {1'b0, opb_q};
        if (rem_shift >= {1'b0, opb_q}) begin
            div_rem  = rem_diff[size-1:0];
            div_quot = {opa_q[size-2:0], 1'b1};
        end else begin
            div_rem  = rem_shift[size-1:0];
            div_quot = {opa_q[size-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_mul_d = is_mul_q;
        acc_d    = acc_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        dbz_d    = dbz_q;
        case (state_q)
            IDLE: begin
                if (ALU_In_Valid) begin
                    if (AluOp_EX == OP_MUL || AluOp_EX == OP_DIVU) begin
                        state_d  = BUSY;
                        cnt_d    = CNT_INIT;
                        is_mul_d = (AluOp_EX == OP_MUL);
                        acc_d    = '0;
                        opa_d    = ALU_A;
                        opb_d    = ALU_B;
                    end else begin
                        state_d  = DONE;
                        result_d = single_res;
                        dbz_d    = 1'b0;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_ONE;
                if (is_mul_q) begin
                    acc_d = mul_acc;
                    opa_d = opa_q << 1;
                    opb_d = opb_q >> 1;
                end else begin
                    acc_d = div_rem;
                    opa_d = div_quot;
                end
                if (cnt_q == CNT_ONE) begin
                    state_d  = DONE;
                    result_d = is_mul_q ? mul_acc : div_quot;
                    dbz_d    = !is_mul_q && (opb_q == '0);
                end
            end
            DONE: begin
                if (ALU_Out_Ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_mul_q <= 1'b0;
            acc_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_mul_q <= is_mul_d;
            acc_q    <= acc_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
        end
    end

    assign ALU_In_Ready  = (state_q == IDLE) && !Reset;
    assign ALU_Out_Valid = (state_q == DONE);
    assign aluResult     = result_q;
    assign Zero          = (result_q == '0);
    assign DivByZero     = dbz_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: a 32-bit and an 8-bit instance share stimulus and are
// compared every cycle against a latency/result model, plus literal expectations.
module tb_alu_multicycle;
    logic        clk = 1'b0;
    logic        rst, in_vld, out_rdy;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [1:0]  in_rdy, out_vld, zero, dbz;
    logic [31:0] res0;
    logic [7:0]  res8;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        dz;
    } vec_t;
    vec_t vecs[$];

    int          mstate [2];
    int          mleft  [2];
    logic [31:0] mres   [2];
    logic [31:0] mpres  [2];
    logic        mdz    [2];
    logic        mpdz   [2];

    always #5 clk = ~clk;

    alu_multicycle #(.size(32)) u_dut32 (
        .Clk(clk), .Reset(rst), .ALU_In_Valid(in_vld), .ALU_In_Ready(in_rdy[0]),
        .AluOp_EX(op), .ALU_A(a), .ALU_B(b), .ALU_Out_Valid(out_vld[0]),
        .ALU_Out_Ready(out_rdy), .aluResult(res0), .Zero(zero[0]), .DivByZero(dbz[0])
    );

    alu_multicycle #(.size(8)) u_dut8 (
        .Clk(clk), .Reset(rst), .ALU_In_Valid(in_vld), .ALU_In_Ready(in_rdy[1]),
        .AluOp_EX(op), .ALU_A(a[7:0]), .ALU_B(b[7:0]), .ALU_Out_Valid(out_vld[1]),
        .ALU_Out_Ready(out_rdy), .aluResult(res8), .Zero(zero[1]), .DivByZero(dbz[1])
    );

    function automatic int wd(input int i);
        return (i == 0) ? 32 : 8;
    endfunction

    function automatic logic [31:0] resv(input int i);
        return (i == 0) ? res0 : {24'h0, res8};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU in plain 64-bit arithmetic, masked to width w.
    function automatic logic [31:0] ref_alu(input int w, input logic [3:0] opc,
                                           input logic [31:0] av, input logic [31:0] bv,
                                           output logic dz);
        longint unsigned m, ua, ub, r;
        longint          sa, sb;
        int              sh;
        m  = (64'd1 << w) - 64'd1;
        ua = {32'h0, av} & m;
        ub = {32'h0, bv} & m;
        sa = longint'(ua << (64 - w)) >>> (64 - w);
        sb = longint'(ub << (64 - w)) >>> (64 - w);
        sh = int'(ua % longint'(w));
        dz = 1'b0;
        case (opc)
            4'h0: r = ua + ub;
            4'h1: r = ua - ub;
            4'h2: r = ua & ub;
            4'h3: r = ua | ub;
            4'h4: r = ~(ua | ub);
            4'h5: r = ua ^ ub;
            4'h6: r = (sa < sb) ? 64'd1 : 64'd0;
            4'h7: r = (sa > sb) ? 64'd1 : 64'd0;
            4'h8: r = ub << sh;
            4'h9: r = ub >> sh;
            4'hA: r = sb >>> sh;
            4'hB: r = ua * ub;
            4'hC: begin
                if (ub == 0) begin
                    r  = m;
                    dz = 1'b1;
                end else begin
                    r = ua / ub;
                end
            end
            4'hD: r = ~(ua & ub);
            4'hE: r = ~(ua ^ ub);
            default: r = m;
        endcase
        r = r & m;
        return r[31:0];
    endfunction

    // Model: 0 = idle, 1 = iterating (mleft edges to go), 2 = result offered.
    always @(posedge clk) begin
        logic [31:0] r;
        logic        d;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mstate[i] = 0;
                mres[i]   = 32'h0;
                mdz[i]    = 1'b0;
            end else begin
                case (mstate[i])
                    0: if (in_vld) begin
                        r = ref_alu(wd(i), op, a, b, d);
                        if (op == 4'hB || op == 4'hC) begin
                            mstate[i] = 1;
                            mleft[i]  = wd(i);
                            mpres[i]  = r;
                            mpdz[i]   = d;
                        end else begin
                            mstate[i] = 2;
                            mres[i]   = r;
                            mdz[i]    = d;
                        end
                    end
                    1: begin
                        mleft[i]--;
                        if (mleft[i] == 0) begin
                            mstate[i] = 2;
                            mres[i]   = mpres[i];
                            mdz[i]    = mpdz[i];
                        end
                    end
                    default: if (out_rdy) mstate[i] = 0;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("w%0d in_rdy", wd(i)), {31'h0, in_rdy[i]}, {31'h0, (mstate[i] == 0) && !rst});
            chk($sformatf("w%0d out_vld", wd(i)), {31'h0, out_vld[i]}, {31'h0, mstate[i] == 2});
            chk($sformatf("w%0d result", wd(i)), resv(i), mres[i]);
            chk($sformatf("w%0d zero", wd(i)), {31'h0, zero[i]}, {31'h0, mres[i] == 32'h0});
            chk($sformatf("w%0d dbz", wd(i)), {31'h0, dbz[i]}, {31'h0, mdz[i]});
        end
    end

    task automatic run_vec(input vec_t v);
        int          n, l0, l1;
        logic        long_op, mdzv;
        logic [31:0] mr;
        long_op = (v.op == 4'hB) || (v.op == 4'hC);
        in_vld = 1'b1;
        op     = v.op;
        a      = v.a;
        b      = v.b;
        @(posedge clk); #1;
        in_vld = 1'b0;
        n  = 1;
        l0 = 0;
        l1 = 0;
        while (n < 100) begin
            if (out_vld[0] && l0 == 0) l0 = n;
            if (out_vld[1] && l1 == 0) l1 = n;
            if (l0 != 0 && l1 != 0) break;
            if (long_op) chk("busy in_rdy32", {31'h0, in_rdy[0] | out_vld[0]}, {31'h0, out_vld[0]});
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("lat32 op%h", v.op), l0, long_op ? 32'd33 : 32'd1);
        chk($sformatf("lat8 op%h", v.op), l1, long_op ? 32'd9 : 32'd1);
        chk($sformatf("res32 op%h", v.op), res0, v.exp);
        chk($sformatf("zero32 op%h", v.op), {31'h0, zero[0]}, {31'h0, v.exp == 32'h0});
        chk($sformatf("dz32 op%h", v.op), {31'h0, dbz[0]}, {31'h0, v.dz});
        mr = ref_alu(32, v.op, v.a, v.b, mdzv);
        chk($sformatf("model32 op%h", v.op), mr, v.exp);
        out_rdy = 1'b1;
        @(posedge clk); #1;
        out_rdy = 1'b0;
        chk("release out_vld32", {31'h0, out_vld[0]}, 32'h0);
        chk("release in_rdy32", {31'h0, in_rdy[0]}, 32'h1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        in_vld  = 1'b0;
        out_rdy = 1'b0;
        op      = 4'h0;
        a       = 32'h0;
        b       = 32'h0;
        vecs.push_back('{4'h0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0});
        vecs.push_back('{4'h1, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0});
        vecs.push_back('{4'h2, 32'h12345678, 32'h0F0F0F0F, 32'h02040608, 1'b0});
        vecs.push_back('{4'h3, 32'h12345678, 32'h0F0F0F0F, 32'h1F3F5F7F, 1'b0});
        vecs.push_back('{4'h4, 32'h12345678, 32'h0F0F0F0F, 32'hE0C0A080, 1'b0});
        vecs.push_back('{4'h5, 32'h12345678, 32'h0F0F0F0F, 32'h1D3B5977, 1'b0});
        vecs.push_back('{4'h6, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0});
        vecs.push_back('{4'h7, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0});
        vecs.push_back('{4'h7, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0});
        vecs.push_back('{4'h8, 32'h00000004, 32'h00000001, 32'h00000010, 1'b0});
        vecs.push_back('{4'hA, 32'h0000001F, 32'h80000000, 32'hFFFFFFFF, 1'b0});
        vecs.push_back('{4'h9, 32'h0000001F, 32'h80000000, 32'h00000001, 1'b0});
        vecs.push_back('{4'hD, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FFF0FFF, 1'b0});
        vecs.push_back('{4'hE, 32'h0F0F0F0F, 32'h00FF00FF, 32'hF00FF00F, 1'b0});
        vecs.push_back('{4'hF, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0});
        vecs.push_back('{4'hB, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 1'b0});
        vecs.push_back('{4'hB, 32'h00010000, 32'h00010000, 32'h00000000, 1'b0});
        vecs.push_back('{4'hB, 32'h00000003, 32'h00000005, 32'h0000000F, 1'b0});
        vecs.push_back('{4'hC, 32'h00000064, 32'h00000007, 32'h0000000E, 1'b0});
        vecs.push_back('{4'hC, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 1'b1});
        vecs.push_back('{4'hC, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b0});
        vecs.push_back('{4'hC, 32'h00000007, 32'h00000064, 32'h00000000, 1'b0});

        repeat (2) @(posedge clk);
        #1;
        chk("reset in_rdy32", {31'h0, in_rdy[0]}, 32'h0);
        chk("reset out_vld32", {31'h0, out_vld[0]}, 32'h0);
        chk("reset res32", res0, 32'h0);
        chk("reset zero32", {31'h0, zero[0]}, 32'h1);
        chk("reset dz32", {31'h0, dbz[0]}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[k]) run_vec(vecs[k]);

        // Back-pressure: result held, new requests ignored.
        in_vld = 1'b1;
        op     = 4'h0;
        a      = 32'h7FFFFFFF;
        b      = 32'h00000001;
        @(posedge clk); #1;
        op = 4'h1;
        a  = 32'h9;
        b  = 32'h9;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp res32", res0, 32'h80000000);
            chk("bp in_rdy32", {31'h0, in_rdy[0]}, 32'h0);
            chk("bp out_vld32", {31'h0, out_vld[0]}, 32'h1);
        end
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        @(posedge clk); #1;
        out_rdy = 1'b0;
        chk("bp release out_vld32", {31'h0, out_vld[0]}, 32'h0);
        chk("bp release in_rdy32", {31'h0, in_rdy[0]}, 32'h1);

        // Reset in the middle of a divide (cycle 10 and cycle 5 after accept).
        for (int t = 0; t < 2; t++) begin
            vec_t add_v;
            in_vld = 1'b1;
            op     = 4'hC;
            a      = 32'd100;
            b      = 32'd7;
            @(posedge clk); #1;
            in_vld = 1'b0;
            repeat ((t == 0) ? 9 : 4) begin
                @(posedge clk); #1;
            end
            rst = 1'b1;
            @(posedge clk); #1;
            chk("abort out_vld32", {31'h0, out_vld[0]}, 32'h0);
            chk("abort out_vld8", {31'h0, out_vld[1]}, 32'h0);
            chk("abort res32", res0, 32'h0);
            chk("abort res8", {24'h0, res8}, 32'h0);
            chk("abort in_rdy32", {31'h0, in_rdy[0]}, 32'h0);
            rst = 1'b0;
            #1;
            chk("abort idle32", {31'h0, in_rdy[0]}, 32'h1);
            chk("abort idle8", {31'h0, in_rdy[1]}, 32'h1);
            @(posedge clk); #1;
            add_v = '{4'h0, 32'h2, 32'h3, 32'h5, 1'b0};
            run_vec(add_v);
            chk("post-abort res8", {24'h0, res8}, 32'h5);
        end

        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
